hdb3_decoder: RTL and testbench

- Receive-side counterpart of the HDB3 encoder chain. Takes the dual-rail bipolar line code (P/N rails) and recovers the NRZ data stream.
- Detects violation (V) pulses by polarity, then removes each V and its matching balancing (B) pulse to restore zero runs.
- Flags line-code errors and keeps a saturating error count for link monitoring.
- Sits between the line-interface sampler and downstream framing logic.

---
 rtl/hdb3_decoder.sv | 99 +++++++++
 tb/tb_hdb3_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdb3_decoder.sv
// HDB3 line decoder: recovers NRZ data from P/N rail samples, strips V/B substitution
// pulses, and flags code violations with a saturating error counter.
module hdb3_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_p,
    input  logic                 data_n,
    output logic                 data_out,
    output logic                 out_valid,
    output logic                 code_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    // pipe[0] is s0 (newest sample), pipe[3] is s3 (oldest)
    logic [3:0] pipe;
    logic       last_pol;
    logic       pol_seen;
    logic       last_vpol;
    logic       vpol_seen;
    logic [2:0] zero_run;
    logic [1:0] fill_cnt;

    logic mark;
    logic illegal;
    logic pol;
    logic is_v;
    logic err_any;

    // P xor N is a mark and P alone gives its polarity; P=N=1 counts as a space
    // for data and leaves the polarity state untouched.
    always_comb begin
        mark    = data_p ^ data_n;
        illegal = data_p & data_n;
        pol     = data_p;
        is_v    = mark && pol_seen && (pol == last_pol);
        err_any = illegal
                | (is_v && (pipe[0] || pipe[1]))
                | (!mark && (zero_run == 3'd3))
                | (is_v && vpol_seen && (pol == last_vpol));
    end

    // NOTE: every register, including the sample pipeline, gets an explicit reset value
    // so a mid-stream reset leaves no stale marks that could later decode as data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe      <= '0;
            last_pol  <= 1'b0;
            pol_seen  <= 1'b0;
            last_vpol <= 1'b0;
            vpol_seen <= 1'b0;
            zero_run  <= '0;
            fill_cnt  <= '0;
            data_out  <= 1'b0;
            out_valid <= 1'b0;
            code_err  <= 1'b0;
            err_count <= '0;
        end else begin
            // NOTE: non-blocking assignments make data_out take the pre-edge s3 even on a V,
            // when the whole pipeline is cleared in the same cycle.
            data_out <= pipe[3];
            if (is_v) begin
                // Clear V and the three positions before it, which removes the B pulse.
                pipe <= '0;
            end else begin
                pipe <= {pipe[2:0], mark};
            end

            if (mark) begin
                last_pol <= pol;
                pol_seen <= 1'b1;
                zero_run <= '0;
            end else if (zero_run != 3'd4) begin
                zero_run <= zero_run + 3'd1;
            end

            if (is_v) begin
                last_vpol <= pol;
                vpol_seen <= 1'b1;
            end

            if (!out_valid) begin
                fill_cnt <= fill_cnt + 2'd1;
                if (fill_cnt == 2'd3) begin
                    out_valid <= 1'b1;
                end
            end

            code_err <= err_any;
            if (err_any && (err_count != ERR_MAX)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdb3_decoder.sv
// Scoreboard bench for hdb3_decoder: a sample-list reference model pushes per-edge
// expectations, and a negedge monitor pops and compares them against the outputs.
module tb_hdb3_decoder;

    localparam int ERR_CNT_W = 8;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 data_p = 1'b0;
    logic                 data_n = 1'b0;
    logic                 data_out;
    logic                 out_valid;
    logic                 code_err;
    logic [ERR_CNT_W-1:0] err_count;

    hdb3_decoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_p    (data_p),
        .data_n    (data_n),
        .data_out  (data_out),
        .out_valid (out_valid),
        .code_err  (code_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        bit    valid;
        bit    data;
        bit    err;
        int    cnt;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    failures = 0;
    string cur_tag = "init";

    // Reference model state: decoded bit per post-reset sample, polarity history,
    // current space-run length and total error count.
    bit dec[$];
    bit have_pol, last_pol, have_vpol, last_vpol;
    int run_len;
    int err_total;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        dec.delete();
        have_pol  = 0;
        last_pol  = 0;
        have_vpol = 0;
        last_vpol = 0;
        run_len   = 0;
        err_total = 0;
    endfunction

    function automatic exp_t model_step(input bit p, input bit n);
        exp_t e;
        int   k = dec.size();
        bit   mark = p ^ n;
        bit   ill = p & n;
        bit   v = mark && have_pol && (p == last_pol);
        bit   err_b = 0;
        bit   err_c, err_d;
        if (v && ((k >= 1 && dec[k-1]) || (k >= 2 && dec[k-2]))) err_b = 1;
        dec.push_back(mark && !v);
        if (v) begin
            for (int j = k - 3; j < k; j++) begin
                if (j >= 0) dec[j] = 0;
            end
        end
        err_d = v && have_vpol && (p == last_vpol);
        if (v) begin
            have_vpol = 1;
            last_vpol = p;
        end
        if (mark) begin
            have_pol = 1;
            last_pol = p;
            run_len  = 0;
        end else begin
            run_len++;
        end
        err_c = !mark && (run_len == 4);
        e.err = ill | err_b | err_c | err_d;
        if (e.err && err_total < CNT_MAX) err_total++;
        e.cnt   = err_total;
        e.valid = (k >= 3);
        e.data  = (k >= 4) ? dec[k-4] : 1'b0;
        e.tag   = cur_tag;
        return e;
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic drive(input bit p, input bit n);
        exp_t e;
        data_p = p;
        data_n = n;
        e = model_step(p, n);
        @(posedge clk);
        #1 exp_q.push_back(e);
        @(negedge clk);
    endtask

    // '+' positive mark, '-' negative mark, '0' space, 'x' illegal P=N=1
    task automatic drive_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "+": drive(1'b1, 1'b0);
                "-": drive(1'b0, 1'b1);
                "x": drive(1'b1, 1'b1);
                default: drive(1'b0, 1'b0);
            endcase
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({cur_tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Called at a negedge; releases reset at a later negedge.
    task automatic reset_dut(input bit check_now);
        rst_n  = 1'b0;
        data_p = 1'b0;
        data_n = 1'b0;
        #1;
        if (check_now) begin
            check({cur_tag, "_rst_data_out"}, int'(data_out), 0);
            check({cur_tag, "_rst_out_valid"}, int'(out_valid), 0);
            check({cur_tag, "_rst_code_err"}, int'(code_err), 0);
            check({cur_tag, "_rst_err_count"}, int'(err_count), 0);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic scenario(input string tag, input string s);
        cur_tag = tag;
        reset_dut(1'b1);
        drive_str(s);
        drain();
    endtask

    // Monitor: pops one expectation for every clock edge the driver issued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, "_out_valid"}, int'(out_valid), int'(e.valid));
                check({e.tag, "_data_out"}, int'(data_out), int'(e.data));
                check({e.tag, "_code_err"}, int'(code_err), int'(e.err));
                check({e.tag, "_err_count"}, int'(err_count), e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(negedge clk);
        scenario("v_basic", "+000+-+-+-");
        scenario("b00v", "+-+00+-+-+-");
        scenario("alternate", "+-+-+-+-+-+-+-+-+-+-");
        scenario("space_run", "+00000-+-+-");
        scenario("illegal", "+-x+-+-+-");
        scenario("v_legal_pair", "+000+-000-+-+-");
        scenario("v_same_pol", "+000+-+00+-+-+-");
        scenario("v_after_mark", "+-++-+-+-");

        // Weighted random line noise; long enough to drive err_count into saturation.
        cur_tag = "random";
        reset_dut(1'b1);
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(99);
            if (r < 40)      drive(1'b0, 1'b0);
            else if (r < 65) drive(1'b1, 1'b0);
            else if (r < 90) drive(1'b0, 1'b1);
            else             drive(1'b1, 1'b1);
        end
        drain();
        check("random_saturated", int'(err_count), CNT_MAX);

        // Reset mid-stream with live outputs; the next '+' must decode as data, not V.
        cur_tag = "mid_pre";
        reset_dut(1'b1);
        drive_str("+-+-+-+x");
        drain();
        cur_tag = "mid_reset";
        reset_dut(1'b1);
        drive_str("+-00+-+-");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
